// File: rtl/cc_handshake_rx_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM encodings and a width helper.
package cc_handshake_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) is 0, so callers clamp to at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/cc_toggle_detect.sv
// Request-toggle edge detector: remembers the last accepted toggle level and flags a change.
// change is combinational and gated by en; pending reports any difference regardless of en.
module cc_toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_tgl,
  output logic change,
  output logic pending
);

  logic req_prev_q;
  logic req_prev_d;

  assign pending = (req_tgl != req_prev_q);
  assign change  = en & pending;

  always_comb begin
    req_prev_d = req_prev_q;
    if (change) req_prev_d = req_tgl;
  end

  always_ff @(posedge clk) begin
    if (rst) req_prev_q <= 1'b0;
    else     req_prev_q <= req_prev_d;
  end

endmodule

// File: rtl/cc_handshake_rx.sv
// Destination side of the two-phase toggle handshake: capture word, hold on valid/ready, return ack toggle.
// out_valid rises 1+SETTLE cycles after a detected toggle; word is held (and ack withheld) until out_ready.
module cc_handshake_rx
  import cc_handshake_rx_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ack_tgl,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int SCNT_RAW = clog2(SETTLE + 1);
  localparam int SCNT_W   = (SCNT_RAW < 1) ? 1 : SCNT_RAW;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   xfer_q, xfer_d;
  logic [SCNT_W-1:0]  settle_q, settle_d;

  logic tog_change;
  logic tog_pending;

  cc_toggle_detect u_toggle_detect (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == ST_IDLE),
    .req_tgl (req_tgl),
    .change  (tog_change),
    .pending (tog_pending)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ack_d    = ack_q;
    xfer_d   = xfer_q;
    settle_d = settle_q;
    // A toggle while a word is in flight means the sender did not wait for ack.
    err_d    = err_q | (tog_pending & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (tog_change) begin
          if (SETTLE == 0) begin
            data_d  = data_in;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            settle_d = SCNT_W'(SETTLE - 1);
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (settle_q == '0) begin
          data_d  = data_in;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          settle_d = settle_q - SCNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          xfer_d  = xfer_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      xfer_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      xfer_q   <= xfer_d;
      settle_q <= settle_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign ack_tgl    = ack_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;
  assign xfer_count = xfer_q;

endmodule
